// File: rtl/imem_pkg.sv
// Shared constants and the pipeline-stage record for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h00000013;
    localparam int          LATENCY_MIN      = 1;
    localparam int          LATENCY_MAX      = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } stage_t;

endpackage

// File: rtl/imem_ram.sv
// Word-addressed single-port RAM with a registered read port; contents are never reset.
module imem_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  re,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Only the read register is cleared so the response word starts at zero.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_server.sv
// Fetch responder: arbitrates the RAM port, classifies requests and delays responses by LATENCY.
module imem_server
    import imem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  exIns_ren,
    input  logic [31:0]           exIns_addr,
    output logic                  exIns_valid,
    output logic [31:0]           exIns_data,
    output logic                  fetch_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  ld_ready,
    output logic [31:0]           fetch_cnt
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_check
        $error("imem_server: LATENCY must lie in 1..4");
    end

    logic                  misaligned;
    logic                  out_of_range;
    logic                  fault;
    logic                  ram_re;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [31:0]           ram_rdata;
    stage_t                stg  [LATENCY];
    stage_t                view [LATENCY];

    assign misaligned   = exIns_addr[1:0] != 2'b00;
    assign out_of_range = exIns_addr[31:DEPTH_LOG2+2] != '0;
    assign fault        = misaligned | out_of_range;
    assign word_idx     = exIns_addr[DEPTH_LOG2+1:2];

    // Fetch owns the port whenever it asks; a write under reset is dropped.
    assign ld_ready = ~exIns_ren;
    assign ram_re   = exIns_ren & ~fault;
    assign ram_we   = ld_en & ld_ready & nrst;
    assign ram_addr = exIns_ren ? word_idx : ld_addr;

    imem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .nrst (nrst),
        .re   (ram_re),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ld_data),
        .rdata(ram_rdata)
    );

    // Stage 1 takes its word straight from the RAM read register.
    always_comb begin
        view[0]      = stg[0];
        view[0].data = stg[0].err ? NOP_WORD : ram_rdata;
        for (int i = 1; i < LATENCY; i++) begin
            view[i] = stg[i];
        end
    end

    // err/data load only with a valid entry, so outputs hold between responses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0].valid <= exIns_ren;
            if (exIns_ren) begin
                stg[0].err <= fault;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stg[i].valid <= view[i-1].valid;
                if (view[i-1].valid) begin
                    stg[i].err  <= view[i-1].err;
                    stg[i].data <= view[i-1].data;
                end
            end
        end
    end

    assign exIns_valid = view[LATENCY-1].valid;
    assign fetch_err   = view[LATENCY-1].err;
    assign exIns_data  = view[LATENCY-1].data;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_cnt <= '0;
        end else if (exIns_valid) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_imem_server.sv
// Drives four responders (LATENCY 1..4) with one stimulus stream and checks each against a reference model.
module tb_imem_server;

    localparam int          NL   = 4;
    localparam int          LOGN = 8192;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        exIns_ren = 1'b0;
    logic [31:0] exIns_addr = '0;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    logic        v [NL];
    logic [31:0] d [NL];
    logic        e [NL];
    logic        r [NL];
    logic [31:0] c [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        imem_server #(
            .DEPTH_LOG2(10),
            .LATENCY   (g + 1),
            .NOP_WORD  (NOP)
        ) dut (
            .clk        (clk),
            .nrst       (nrst),
            .exIns_ren  (exIns_ren),
            .exIns_addr (exIns_addr),
            .exIns_valid(v[g]),
            .exIns_data (d[g]),
            .fetch_err  (e[g]),
            .ld_en      (ld_en),
            .ld_addr    (ld_addr),
            .ld_data    (ld_data),
            .ld_ready   (r[g]),
            .fetch_cnt  (c[g])
        );
    end

    // Reference model: one response record per clock edge, RAM as a plain array.
    int          n = -1;
    int          rst_edge = -1;
    logic [31:0] mem_m [1024];
    logic        mv [LOGN];
    logic        me [LOGN];
    logic [31:0] md [LOGN];

    always @(posedge clk) begin
        n++;
        mv[n] = 1'b0;
        me[n] = 1'b0;
        md[n] = '0;
        if (!nrst) begin
            rst_edge = n;
        end else if (exIns_ren) begin
            mv[n] = 1'b1;
            if (exIns_addr[1:0] != 2'b00 || exIns_addr[31:2] >= 30'd1024) begin
                me[n] = 1'b1;
                md[n] = NOP;
            end else begin
                md[n] = mem_m[exIns_addr[11:2]];
            end
        end else if (ld_en) begin
            mem_m[ld_addr] = ld_data;
        end
    end

    int errors = 0;
    int checks = 0;
    int cnt_exp [NL];

    logic        log_v [NL][LOGN];
    logic [31:0] log_d [NL][LOGN];
    logic        log_e [NL][LOGN];
    logic        log_r [NL][LOGN];
    logic [31:0] log_c [NL][LOGN];

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s lat=%0d edge=%0d: got %h expected %h", name, g + 1, n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n >= 0) begin
            for (int g = 0; g < NL; g++) begin
                int   s;
                logic ev;
                log_v[g][n] = v[g];
                log_d[g][n] = d[g];
                log_e[g][n] = e[g];
                log_r[g][n] = r[g];
                log_c[g][n] = c[g];
                if (!nrst) begin
                    cnt_exp[g] = 0;
                    chk("reset_valid", g, {31'd0, v[g]}, 32'd0);
                    chk("reset_data", g, d[g], 32'd0);
                    chk("reset_err", g, {31'd0, e[g]}, 32'd0);
                    chk("reset_cnt", g, c[g], 32'd0);
                end else begin
                    s  = n - g;
                    ev = (s >= 0) && (s > rst_edge) && mv[s];
                    chk("valid", g, {31'd0, v[g]}, {31'd0, ev});
                    if (ev) begin
                        chk("data", g, d[g], md[s]);
                        chk("err", g, {31'd0, e[g]}, {31'd0, me[s]});
                    end
                    chk("ld_ready", g, {31'd0, r[g]}, {31'd0, ~exIns_ren});
                    chk("fetch_cnt", g, c[g], cnt_exp[g]);
                    if (ev) cnt_exp[g]++;
                end
            end
        end
    end

    task automatic step(input logic rs, input logic ren, input logic [31:0] a,
                        input logic le, input logic [9:0] la, input logic [31:0] ldv,
                        output int ed);
        @(negedge clk);
        #1;
        nrst       = rs;
        exIns_ren  = ren;
        exIns_addr = a;
        ld_en      = le;
        ld_addr    = la;
        ld_data    = ldv;
        ed         = n + 1;
    endtask

    task automatic idle(input int k);
        int ed;
        for (int i = 0; i < k; i++) step(1'b1, 1'b0, '0, 1'b0, '0, '0, ed);
    endtask

    initial begin
        int          ed, e1, ecol, ef, efault, ea, ereb;
        logic        pend;
        logic [9:0]  pa;
        logic [31:0] pd;
        logic [31:0] lit [4];
        logic [31:0] flt [3];
        lit[0] = 32'h00100093;
        lit[1] = 32'h00200113;
        lit[2] = 32'h00308193;
        lit[3] = 32'h00418213;
        flt[0] = 32'h00000002;
        flt[1] = 32'h00001000;
        flt[2] = 32'hFFFFFFFC;
        for (int g = 0; g < NL; g++) cnt_exp[g] = 0;

        step(1'b0, 1'b0, '0, 1'b0, '0, '0, ed);
        step(1'b0, 1'b0, '0, 1'b0, '0, '0, ed);
        for (int w = 0; w < 1024; w++)
            step(1'b1, 1'b0, '0, 1'b1, w[9:0], (w < 4) ? lit[w] : $urandom, ed);
        idle(1);

        // Load then fetch
        step(1'b1, 1'b1, 32'h0, 1'b0, '0, '0, e1);
        step(1'b1, 1'b1, 32'h4, 1'b0, '0, '0, ed);
        step(1'b1, 1'b1, 32'h8, 1'b0, '0, '0, ed);
        step(1'b1, 1'b1, 32'hC, 1'b0, '0, '0, ed);
        idle(6);

        // Loader held off by three fetches, then commits
        step(1'b1, 1'b1, 32'h10, 1'b1, 10'd5, 32'hDEADBEEF, ecol);
        step(1'b1, 1'b1, 32'h18, 1'b1, 10'd5, 32'hDEADBEEF, ed);
        step(1'b1, 1'b1, 32'h1C, 1'b1, 10'd5, 32'hDEADBEEF, ed);
        step(1'b1, 1'b0, 32'h0, 1'b1, 10'd5, 32'hDEADBEEF, ed);
        step(1'b1, 1'b1, 32'h14, 1'b0, '0, '0, ef);
        idle(6);

        // Faulting fetches
        step(1'b1, 1'b1, flt[0], 1'b0, '0, '0, efault);
        step(1'b1, 1'b1, flt[1], 1'b0, '0, '0, ed);
        step(1'b1, 1'b1, flt[2], 1'b0, '0, '0, ed);
        idle(6);

        // Reset mid-stream with a loader write that must be dropped
        step(1'b1, 1'b1, 32'h0, 1'b0, '0, '0, ea);
        step(1'b1, 1'b1, 32'h4, 1'b0, '0, '0, ed);
        step(1'b0, 1'b0, 32'h0, 1'b1, 10'd0, 32'hBADBAD00, ed);
        idle(6);
        step(1'b1, 1'b1, 32'h0, 1'b0, '0, '0, ereb);
        idle(6);

        // Randomized traffic with a stable-until-accepted loader
        pend = 1'b0;
        pa   = '0;
        pd   = '0;
        for (int k = 0; k < 3000; k++) begin
            logic        ren;
            logic        rs;
            logic [31:0] a;
            if (!pend && $urandom_range(3) == 0) begin
                pend = 1'b1;
                pa   = 10'($urandom);
                pd   = $urandom;
            end
            ren = 1'($urandom_range(1));
            case ($urandom_range(15))
                0: begin a = $urandom; a[1:0] = 2'($urandom_range(3, 1)); end
                1: begin a = $urandom | 32'h00001000; a[1:0] = 2'b00; end
                2: a = 32'hFFFFFFFC;
                default: a = {20'd0, 10'($urandom), 2'b00};
            endcase
            rs = ($urandom_range(299) != 0);
            step(rs, ren, a, pend, pa, pd, ed);
            if (rs && pend && !ren) pend = 1'b0;
        end
        idle(6);

        // Hand-computed expectations taken from the recorded outputs
        for (int g = 0; g < NL; g++) begin
            chk("s1_no_early", g, {31'd0, log_v[g][e1 + g - 1]}, 32'd0);
            for (int k = 0; k < 4; k++) begin
                chk("s1_valid", g, {31'd0, log_v[g][e1 + g + k]}, 32'd1);
                chk("s1_data", g, log_d[g][e1 + g + k], lit[k]);
                chk("s1_err", g, {31'd0, log_e[g][e1 + g + k]}, 32'd0);
            end
            chk("s1_no_extra", g, {31'd0, log_v[g][e1 + g + 4]}, 32'd0);
            chk("s1_cnt", g, log_c[g][e1 + g + 4], 32'd4);
            for (int k = 0; k < 3; k++)
                chk("col_ready_low", g, {31'd0, log_r[g][ecol + k]}, 32'd0);
            chk("col_ready_high", g, {31'd0, log_r[g][ecol + 3]}, 32'd1);
            chk("col_valid", g, {31'd0, log_v[g][ef + g]}, 32'd1);
            chk("col_data", g, log_d[g][ef + g], 32'hDEADBEEF);
            for (int k = 0; k < 3; k++) begin
                chk("fault_valid", g, {31'd0, log_v[g][efault + g + k]}, 32'd1);
                chk("fault_data", g, log_d[g][efault + g + k], NOP);
                chk("fault_err", g, {31'd0, log_e[g][efault + g + k]}, 32'd1);
            end
            chk("rst_cnt", g, log_c[g][ea + 3], 32'd0);
            chk("reb_valid", g, {31'd0, log_v[g][ereb + g]}, 32'd1);
            chk("reb_data", g, log_d[g][ereb + g], 32'h00100093);
        end
        chk("rst_drop_a", 2, {31'd0, log_v[2][ea + 2]}, 32'd0);
        chk("rst_drop_b", 2, {31'd0, log_v[2][ea + 3]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
